dest_drain: RTL

Destination-side drain stage for the PCIe interconnect. It sits directly downstream of the destination FIFOs D0/D1, generates `pop_D0`/`pop_D1` from their empty flags with round-robin arbitration, and presents one word at a time to a sink through a valid/ready handshake. It also counts delivered words per destination and flags words whose destination bit does not match the FIFO they came from.

---
 rtl/dest_drain.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/dest_drain.sv
// Drain stage behind destination FIFOs D0/D1: round-robin pop, capture, valid/ready delivery.
// Keeps per-destination saturating delivery counters and a sticky misroute flag.
module dest_drain #(
  parameter int unsigned WORD_SIZE = 6,
  parameter int unsigned DEST_BIT  = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 enable,
  input  logic                 clear_counts,
  input  logic                 empty_D0,
  input  logic                 empty_D1,
  input  logic [WORD_SIZE-1:0] data_D0,
  input  logic [WORD_SIZE-1:0] data_D1,
  input  logic                 ready_out,
  output logic                 pop_D0,
  output logic                 pop_D1,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 valid_out,
  output logic                 dest_out,
  output logic [CNT_W-1:0]     count_D0,
  output logic [CNT_W-1:0]     count_D1,
  output logic                 misroute
);

  typedef enum logic [1:0] {StIdle, StArb, StFetch, StSend} state_e;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e               r_state;
  state_e               w_state_d;
  logic                 r_last;
  logic [WORD_SIZE-1:0] r_data;
  logic                 r_valid;
  logic                 r_dest;
  logic [CNT_W-1:0]     r_cnt0;
  logic [CNT_W-1:0]     r_cnt1;
  logic                 r_misroute;

  logic                 w_any;
  logic                 w_pick;
  logic                 w_hs;
  logic                 w_pop;
  logic [WORD_SIZE-1:0] w_fetch;

  always_comb begin
    w_any = ~empty_D0 | ~empty_D1;
    // With a single non-empty FIFO, empty_D0 alone tells which one it is.
    if (~empty_D0 & ~empty_D1) begin
      w_pick = ~r_last;
    end else begin
      w_pick = empty_D0;
    end
    w_hs  = (r_state == StSend) & ready_out;
    w_pop = enable & w_any & ((r_state == StArb) | w_hs);
  end

  assign pop_D0  = w_pop & ~w_pick;
  assign pop_D1  = w_pop & w_pick;
  // r_last holds the FIFO popped in the previous cycle, i.e. the one being fetched.
  assign w_fetch = r_last ? data_D1 : data_D0;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (enable) w_state_d = StArb;
      StArb: begin
        if (!enable) begin
          w_state_d = StIdle;
        end else if (w_any) begin
          w_state_d = StFetch;
        end
      end
      StFetch: w_state_d = StSend;
      StSend: begin
        if (ready_out) begin
          if (w_pop) begin
            w_state_d = StFetch;
          end else if (enable) begin
            w_state_d = StArb;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state    <= StIdle;
      r_last     <= 1'b1;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_dest     <= 1'b0;
      r_misroute <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_pop) begin
        r_last <= w_pick;
      end
      if (r_state == StFetch) begin
        r_data  <= w_fetch;
        r_dest  <= r_last;
        r_valid <= 1'b1;
        if (w_fetch[DEST_BIT] != r_last) begin
          r_misroute <= 1'b1;
        end
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (clear_counts) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_hs) begin
      if (!r_dest && (r_cnt0 != CntMax)) begin
        r_cnt0 <= r_cnt0 + CntOne;
      end
      if (r_dest && (r_cnt1 != CntMax)) begin
        r_cnt1 <= r_cnt1 + CntOne;
      end
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign dest_out  = r_dest;
  assign count_D0  = r_cnt0;
  assign count_D1  = r_cnt1;
  assign misroute  = r_misroute;

endmodule
